// File: rtl/exec_mem_cc_reg_if.sv
// rtl/exec_mem_cc_reg_if.sv - E-to-M boundary signal bundle with master/slave views
interface exec_mem_cc_reg_if #(
  parameter int W = 64
);
  logic         e_valid;
  logic [3:0]   e_icode;
  logic [3:0]   e_ifun;
  logic [1:0]   alu_fun;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         set_cc;
  logic [3:0]   e_dstE;
  logic         m_stall;
  logic         m_bubble;
  logic         e_cnd;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;
  logic         m_valid;
  logic [3:0]   m_icode;
  logic         m_cnd;
  logic [W-1:0] m_valE;
  logic [3:0]   m_dstE;

  modport master (
    output e_valid, e_icode, e_ifun, alu_fun, alu_a, alu_b, alu_out,
           set_cc, e_dstE, m_stall, m_bubble,
    input  e_cnd, cc_zf, cc_sf, cc_of, m_valid, m_icode, m_cnd, m_valE, m_dstE
  );

  modport slave (
    input  e_valid, e_icode, e_ifun, alu_fun, alu_a, alu_b, alu_out,
           set_cc, e_dstE, m_stall, m_bubble,
    output e_cnd, cc_zf, cc_sf, cc_of, m_valid, m_icode, m_cnd, m_valE, m_dstE
  );
endinterface

// File: rtl/exec_mem_cc_reg.sv
// rtl/exec_mem_cc_reg.sv - Y86-64 E/M pipeline register with condition codes
// Condition codes and the M register share the stall; a bubble loads a NOP and blocks CC writes.
module exec_mem_cc_reg #(
  parameter int         W       = 64,
  parameter logic [3:0] RNONE   = 4'hF,
  parameter logic [3:0] INOP    = 4'h1,
  parameter logic [3:0] IRRMOVQ = 4'h2
) (
  input logic             clk,
  input logic             rst_n,
  exec_mem_cc_reg_if.slave bus
);
  logic         zf_q, sf_q, of_q;
  logic         zf_d, sf_d, of_d;
  logic         m_valid_q, m_valid_d;
  logic [3:0]   m_icode_q, m_icode_d;
  logic         m_cnd_q, m_cnd_d;
  logic [W-1:0] m_vale_q, m_vale_d;
  logic [3:0]   m_dste_q, m_dste_d;

  logic cnd, lt, zf_n, sf_n, of_n, cc_we;

  // Condition uses the CC held before this edge; there is no forwarding of the new flags.
  always_comb begin
    lt = sf_q ^ of_q;
    case (bus.e_ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = lt | zf_q;
      4'd2:    cnd = lt;
      4'd3:    cnd = zf_q;
      4'd4:    cnd = ~zf_q;
      4'd5:    cnd = ~lt;
      4'd6:    cnd = ~lt & ~zf_q;
      default: cnd = 1'b0;
    endcase
  end

  always_comb begin
    zf_n = (bus.alu_out == '0);
    sf_n = bus.alu_out[W-1];
    case (bus.alu_fun)
      2'd0:    of_n = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (bus.alu_out[W-1] != bus.alu_a[W-1]);
      2'd1:    of_n = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (bus.alu_out[W-1] != bus.alu_b[W-1]);
      default: of_n = 1'b0;
    endcase
  end

  assign cc_we = bus.e_valid & bus.set_cc & ~bus.m_stall & ~bus.m_bubble;

  always_comb begin
    zf_d      = zf_q;
    sf_d      = sf_q;
    of_d      = of_q;
    m_valid_d = m_valid_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_dste_d  = m_dste_q;
    if (cc_we) begin
      zf_d = zf_n;
      sf_d = sf_n;
      of_d = of_n;
    end
    if (!bus.m_stall) begin
      if (bus.m_bubble) begin
        m_valid_d = 1'b0;
        m_icode_d = INOP;
        m_cnd_d   = 1'b0;
        m_vale_d  = '0;
        m_dste_d  = RNONE;
      end else begin
        m_valid_d = bus.e_valid;
        m_icode_d = bus.e_icode;
        m_cnd_d   = cnd;
        m_vale_d  = bus.alu_out;
        // A dead slot or a failed cmov must not write the register file.
        m_dste_d  = (!bus.e_valid || (bus.e_icode == IRRMOVQ && !cnd)) ? RNONE : bus.e_dstE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_icode_q <= INOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_dste_q  <= RNONE;
    end else begin
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
      m_valid_q <= m_valid_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_dste_q  <= m_dste_d;
    end
  end

  assign bus.e_cnd   = cnd;
  assign bus.cc_zf   = zf_q;
  assign bus.cc_sf   = sf_q;
  assign bus.cc_of   = of_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_icode = m_icode_q;
  assign bus.m_cnd   = m_cnd_q;
  assign bus.m_valE  = m_vale_q;
  assign bus.m_dstE  = m_dste_q;
endmodule

// File: tb/tb_exec_mem_cc_reg.sv
// tb/tb_exec_mem_cc_reg.sv - vector table, directed sequences and random run against a reference model
module tb_exec_mem_cc_reg;
  localparam int W = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exec_mem_cc_reg_if #(.W(W)) bus ();
  exec_mem_cc_reg #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic        mzf, msf, mof, mvalid, mcnd;
  logic [3:0]  micode, mdst;
  logic [63:0] mvale;

  typedef struct {
    logic        valid; logic [3:0] icode; logic [3:0] ifun; logic [1:0] fun;
    logic [63:0] a; logic [63:0] b; logic [63:0] out; logic set; logic [3:0] dst;
    logic        stall; logic bubble;
    logic        x_cnd; logic x_zf; logic x_sf; logic x_of;
    logic        x_valid; logic [3:0] x_icode; logic x_mcnd; logic [63:0] x_vale; logic [3:0] x_dst;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond(input logic [3:0] f, input logic z, input logic s, input logic o);
    case (f)
      4'd0: return 1'b1;
      4'd1: return (s != o) || z;
      4'd2: return s != o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return s == o;
      4'd6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Overflow means the exact signed result does not fit back into the 64-bit output.
  function automatic logic ovf(input logic [1:0] fun, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] out);
    logic signed [65:0] exact;
    logic signed [65:0] got;
    got = $signed({{2{out[63]}}, out});
    if (fun == 2'd0)      exact = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
    else if (fun == 2'd1) exact = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
    else return 1'b0;
    return exact != got;
  endfunction

  function automatic logic [63:0] alu(input logic [1:0] fun, input logic [63:0] a, input logic [63:0] b);
    case (fun)
      2'd0: return a + b;
      2'd1: return b - a;
      2'd2: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model_reset();
    mzf = 1; msf = 0; mof = 0; mvalid = 0; micode = 4'h1; mcnd = 0; mvale = '0; mdst = 4'hF;
  endtask

  task automatic model_edge();
    logic c;
    c = cond(bus.e_ifun, mzf, msf, mof);
    if (!bus.m_stall && !bus.m_bubble) begin
      if (bus.e_valid && bus.set_cc) begin
        mzf = (bus.alu_out == 0);
        msf = $signed(bus.alu_out) < 0;
        mof = ovf(bus.alu_fun, bus.alu_a, bus.alu_b, bus.alu_out);
      end
      mvalid = bus.e_valid; micode = bus.e_icode; mcnd = c; mvale = bus.alu_out;
      mdst = (!bus.e_valid || (bus.e_icode == 4'h2 && !c)) ? 4'hF : bus.e_dstE;
    end else if (!bus.m_stall) begin
      mvalid = 0; micode = 4'h1; mcnd = 0; mvale = '0; mdst = 4'hF;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".zf"}, bus.cc_zf, mzf);
    chk({tag, ".sf"}, bus.cc_sf, msf);
    chk({tag, ".of"}, bus.cc_of, mof);
    chk({tag, ".m_valid"}, bus.m_valid, mvalid);
    chk({tag, ".m_icode"}, bus.m_icode, micode);
    chk({tag, ".m_cnd"}, bus.m_cnd, mcnd);
    chk({tag, ".m_valE"}, bus.m_valE, mvale);
    chk({tag, ".m_dstE"}, bus.m_dstE, mdst);
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] ifn, input logic [1:0] fun,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] out,
                       input logic set, input logic [3:0] dst, input logic st, input logic bb);
    bus.e_valid = v; bus.e_icode = ic; bus.e_ifun = ifn; bus.alu_fun = fun;
    bus.alu_a = a; bus.alu_b = b; bus.alu_out = out; bus.set_cc = set;
    bus.e_dstE = dst; bus.m_stall = st; bus.m_bubble = bb;
  endtask

  // Inputs are applied 1 time unit after a rising edge; this settles, checks, and crosses one edge.
  task automatic step(input string tag);
    #1;
    chk({tag, ".e_cnd"}, bus.e_cnd, cond(bus.e_ifun, mzf, msf, mof));
    model_edge();
    @(posedge clk); #1;
    check_model(tag);
  endtask

  initial begin
    vt[0]  = '{1,4'h6,4'h2,2'd2,ONES,ONES,ONES,1,4'h3,0,0,  0, 0,1,0, 1,4'h6,0,ONES,4'h3};
    vt[1]  = '{1,4'h6,4'h0,2'd0,64'h7FFF_FFFF_FFFF_FFFF,64'h7FFF_FFFF_FFFF_FFFF,64'hFFFF_FFFF_FFFF_FFFE,1,4'h4,0,0,
               1, 0,1,1, 1,4'h6,1,64'hFFFF_FFFF_FFFF_FFFE,4'h4};
    vt[2]  = '{1,4'h6,4'h1,2'd1,64'h1,64'h8000_0000_0000_0000,64'h7FFF_FFFF_FFFF_FFFF,1,4'h5,0,0,
               0, 0,0,1, 1,4'h6,0,64'h7FFF_FFFF_FFFF_FFFF,4'h5};
    vt[3]  = '{1,4'h6,4'h3,2'd3,64'h5,64'h5,64'h0,1,4'h6,0,0,   0, 1,0,0, 1,4'h6,0,64'h0,4'h6};
    vt[4]  = '{1,4'h7,4'h3,2'd0,64'h0,64'h0,64'h100,0,4'hF,0,0, 1, 1,0,0, 1,4'h7,1,64'h100,4'hF};
    vt[5]  = '{1,4'h7,4'h4,2'd0,64'h0,64'h0,64'h104,0,4'hF,0,0, 0, 1,0,0, 1,4'h7,0,64'h104,4'hF};
    vt[6]  = '{1,4'h7,4'h1,2'd0,64'h0,64'h0,64'h108,0,4'hF,0,0, 1, 1,0,0, 1,4'h7,1,64'h108,4'hF};
    vt[7]  = '{1,4'h7,4'h6,2'd0,64'h0,64'h0,64'h10C,0,4'hF,0,0, 0, 1,0,0, 1,4'h7,0,64'h10C,4'hF};
    vt[8]  = '{1,4'h2,4'h4,2'd0,64'h0,64'h42,64'h42,0,4'h7,0,0, 0, 1,0,0, 1,4'h2,0,64'h42,4'hF};
    vt[9]  = '{1,4'h2,4'h3,2'd0,64'h0,64'h43,64'h43,0,4'h7,0,0, 1, 1,0,0, 1,4'h2,1,64'h43,4'h7};
    vt[10] = '{0,4'h6,4'h0,2'd0,64'h1,64'h1,64'h99,1,4'h8,0,0,  1, 1,0,0, 0,4'h6,1,64'h99,4'hF};
    vt[11] = '{1,4'h6,4'h0,2'd0,64'h1,64'h1,64'h2,1,4'h9,0,1,   1, 1,0,0, 0,4'h1,0,64'h0,4'hF};

    drive(0, 4'h1, 4'h0, 2'd0, '0, '0, '0, 0, 4'hF, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].valid, vt[i].icode, vt[i].ifun, vt[i].fun, vt[i].a, vt[i].b, vt[i].out,
            vt[i].set, vt[i].dst, vt[i].stall, vt[i].bubble);
      #1;
      chk($sformatf("vec%0d.e_cnd", i), bus.e_cnd, vt[i].x_cnd);
      model_edge();
      @(posedge clk); #1;
      chk($sformatf("vec%0d.zf", i), bus.cc_zf, vt[i].x_zf);
      chk($sformatf("vec%0d.sf", i), bus.cc_sf, vt[i].x_sf);
      chk($sformatf("vec%0d.of", i), bus.cc_of, vt[i].x_of);
      chk($sformatf("vec%0d.m_valid", i), bus.m_valid, vt[i].x_valid);
      chk($sformatf("vec%0d.m_icode", i), bus.m_icode, vt[i].x_icode);
      chk($sformatf("vec%0d.m_cnd", i), bus.m_cnd, vt[i].x_mcnd);
      chk($sformatf("vec%0d.m_valE", i), bus.m_valE, vt[i].x_vale);
      chk($sformatf("vec%0d.m_dstE", i), bus.m_dstE, vt[i].x_dst);
    end

    // Load a live instruction that leaves SF=1, then freeze for three cycles with flag-changing inputs.
    drive(1, 4'h6, 4'h0, 2'd1, 64'h10, 64'h3, 64'h3 - 64'h10, 1, 4'hA, 0, 0);
    step("preload");
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'h6, 4'h0, 2'd3, 64'h77 + i, 64'h77 + i, 64'h0, 1, 4'h2 + 4'(i), 1, 0);
      step($sformatf("stall%0d", i));
    end
    drive(1, 4'h6, 4'h0, 2'd3, 64'h5, 64'h5, 64'h0, 1, 4'hB, 1, 1);
    step("stall_bubble");
    drive(1, 4'h6, 4'h0, 2'd3, 64'h5, 64'h5, 64'h0, 1, 4'hB, 0, 1);
    step("bubble");
    chk("bubble.icode_nop", bus.m_icode, 4'h1);
    chk("bubble.sf_kept", bus.cc_sf, 1'b1);

    // Asynchronous reset between edges while stalled.
    drive(1, 4'h6, 4'h0, 2'd0, 64'h1, 64'h1, 64'h2, 1, 4'h3, 0, 0);
    step("pre_reset");
    drive(1, 4'h6, 4'h0, 2'd0, 64'h1, 64'h1, 64'h2, 1, 4'h3, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_model("reset_held");

    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        logic [63:0] a, b;
        a = ONES - 64'(i);
        b = ONES - 64'(j);
        drive(1, 4'h6, 4'h2, 2'd2, a, b, a & b, 1, 4'h1, 0, 0);
        step("sweep");
      end
    end

    for (int i = 0; i < 400; i++) begin
      logic [63:0] a, b;
      logic [1:0]  fun;
      logic [3:0]  ic;
      a   = {$urandom, $urandom};
      b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) a = {$urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF};
      fun = 2'($urandom_range(0, 3));
      ic  = ($urandom_range(0, 2) == 0) ? 4'h2 : 4'($urandom_range(0, 15));
      drive($urandom_range(0, 7) != 0, ic, 4'($urandom_range(0, 15)), fun, a, b, alu(fun, a, b),
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
